// File: rtl/ct_loader_pkg.sv
// ct_loader_pkg: shared state encoding and constants for the ciphertext loader.
package ct_loader_pkg;
  typedef enum logic [3:0] {
    RSTCRK, IDLE, LOAD, DRAIN, HDR, START, WAIT_LO, WAIT_HI, DONE
  } state_t;
  localparam logic [7:0] CT_LEN_ADDR = 8'd0;
  localparam int KEY_W = 24;
endpackage

// File: rtl/ct_loader.sv
// ct_loader: stores a host byte stream as a length-prefixed message in ct memory,
// then starts the search core and captures its key result.
module ct_loader
  import ct_loader_pkg::*;
#(
  parameter logic [7:0] MAX_LEN = 8'd255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic [7:0]       ct_addr,
  output logic [7:0]       ct_wrdata,
  output logic             ct_wren,
  output logic             crk_rst_n,
  output logic             crk_en,
  input  logic             crk_rdy,
  input  logic [KEY_W-1:0] crk_key,
  input  logic             crk_key_valid,
  input  logic             clear,
  output logic             done,
  output logic [KEY_W-1:0] key,
  output logic             key_valid,
  output logic             err
);
  state_t state;
  logic [7:0] len;
  logic take;
  assign in_ready = state inside {IDLE, LOAD, DRAIN};
  assign take = in_valid && in_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= RSTCRK;
      len       <= 8'd0;
      ct_wren   <= 1'b0;
      ct_addr   <= 8'd0;
      ct_wrdata <= 8'd0;
      crk_en    <= 1'b0;
      crk_rst_n <= 1'b0;
      done      <= 1'b0;
      key       <= '0;
      key_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      ct_wren <= 1'b0;
      crk_en  <= 1'b0;
      case (state)
        RSTCRK: begin
          crk_rst_n <= 1'b1;
          state     <= IDLE;
        end
        IDLE: if (take) begin
          len       <= 8'd1;
          err       <= 1'b0;
          ct_wren   <= 1'b1;
          ct_addr   <= 8'd1;
          ct_wrdata <= in_data;
          state     <= in_last ? HDR : LOAD;
        end
        LOAD: if (take) begin
          // a byte beyond MAX_LEN is never stored, even if it is the last one
          if (len == MAX_LEN) begin
            err       <= 1'b1;
            crk_rst_n <= !in_last;
            state     <= in_last ? RSTCRK : DRAIN;
          end else begin
            len       <= len + 8'd1;
            ct_wren   <= 1'b1;
            ct_addr   <= len + 8'd1;
            ct_wrdata <= in_data;
            state     <= in_last ? HDR : LOAD;
          end
        end
        DRAIN: if (take && in_last) begin
          crk_rst_n <= 1'b0;
          state     <= RSTCRK;
        end
        HDR: begin
          ct_wren   <= 1'b1;
          ct_addr   <= CT_LEN_ADDR;
          ct_wrdata <= len;
          state     <= START;
        end
        START: if (crk_rdy) begin
          crk_en <= 1'b1;
          state  <= WAIT_LO;
        end
        WAIT_LO: if (!crk_rdy) state <= WAIT_HI;
        WAIT_HI: if (crk_rdy) begin
          key       <= crk_key;
          key_valid <= crk_key_valid;
          done      <= 1'b1;
          state     <= DONE;
        end
        DONE: if (clear) begin
          done      <= 1'b0;
          key       <= '0;
          key_valid <= 1'b0;
          crk_rst_n <= 1'b0;
          state     <= RSTCRK;
        end
        default: state <= RSTCRK;
      endcase
    end
endmodule
